inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 123 ++++++++++++
 tb/tb_inst_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// A circular FIFO of DEPTH {pc, inst} entries. Enqueue side: enq_valid_i /
// enq_ready_o. Dequeue side: deq_valid_o / deq_ready_i. On both sides a
// transfer happens on a rising edge where valid and ready are both high and
// flush_i is low. Valid never waits on ready. enq_ready_o and deq_valid_o
// depend only on registered state. A flush discards every entry and ignores
// both handshakes in that cycle. The storage array is not reset; the
// occupancy count decides what is visible.
module inst_queue #(
    parameter int unsigned DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         enq_valid_i,
    input  logic [31:0]                  enq_pc_i,
    input  logic [31:0]                  enq_inst_i,
    output logic                         enq_ready_o,
    output logic                         almost_full_o,
    output logic                         deq_valid_o,
    output logic [31:0]                  deq_pc_o,
    output logic [31:0]                  deq_inst_o,
    input  logic                         deq_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // The pointers wrap for free only when DEPTH is a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_queue: DEPTH must be a power of two and at least 2");
    end

    // Registered state
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Entry storage (no reset needed)
    logic [31:0] mem_pc_q   [DEPTH];
    logic [31:0] mem_inst_q [DEPTH];

    // Handshake qualifiers
    logic enq_fire;
    logic deq_fire;

    // Status outputs come from the registered count only
    always_comb begin
        enq_ready_o   = (count_q != FULL_CNT);
        almost_full_o = (count_q >= AF_CNT);
        deq_valid_o   = (count_q != '0);
        count_o       = count_q;
    end

    // Head entry, or the idle pattern when empty
    always_comb begin
        deq_pc_o   = 32'h0;
        deq_inst_o = NOP;
        if (deq_valid_o) begin
            deq_pc_o   = mem_pc_q[rd_ptr_q];
            deq_inst_o = mem_inst_q[rd_ptr_q];
        end
    end

    // Transfers happen only when not flushing
    always_comb begin
        enq_fire = enq_valid_i && enq_ready_o && !flush_i;
        deq_fire = deq_valid_o && deq_ready_i && !flush_i;
    end

    // Next-state for pointers and count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers, cleared by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write the accepted entry at the write pointer
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem_pc_q[wr_ptr_q]   <= enq_pc_i;
            mem_inst_q[wr_ptr_q] <= enq_inst_i;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Testbench for inst_queue (DEPTH=4, non-zero NOP).
// A vector table drives the queue cycle by cycle and gives the expected
// status after each edge. A scoreboard queue holds the accepted {pc, inst}
// entries and checks the head before every edge.
module tb_inst_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              enq_valid;
  logic [31:0]       enq_pc;
  logic [31:0]       enq_inst;
  logic              enq_ready;
  logic              almost_full;
  logic              deq_valid;
  logic [31:0]       deq_pc;
  logic [31:0]       deq_inst;
  logic              deq_ready;
  logic [CNT_W-1:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic        fl;
    logic        ev;
    logic [31:0] pc;
    logic        dr;
    int          cnt;
    logic        af;
    logic        rdy;
    logic        val;
  } vec_t;

  vec_t vecs[$];

  inst_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .enq_valid_i   (enq_valid),
    .enq_pc_i      (enq_pc),
    .enq_inst_i    (enq_inst),
    .enq_ready_o   (enq_ready),
    .almost_full_o (almost_full),
    .deq_valid_o   (deq_valid),
    .deq_pc_o      (deq_pc),
    .deq_inst_o    (deq_inst),
    .deq_ready_i   (deq_ready),
    .count_o       (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ (pc * 32'd7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic fl, input logic ev, input logic [31:0] pc,
                         input logic dr, input int cnt, input logic af,
                         input logic rdy, input logic val);
    vec_t v;
    v.fl = fl; v.ev = ev; v.pc = pc; v.dr = dr;
    v.cnt = cnt; v.af = af; v.rdy = rdy; v.val = val;
    vecs.push_back(v);
  endtask

  // scoreboard: head and occupancy against the expected queue
  task automatic check_head();
    chk("count", 32'(count), 32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      chk("deq_valid", 32'(deq_valid), 32'd1);
      chk("deq_pc", deq_pc, exp_q[0][63:32]);
      chk("deq_inst", deq_inst, exp_q[0][31:0]);
    end else begin
      chk("deq_valid_empty", 32'(deq_valid), 32'd0);
      chk("deq_pc_empty", deq_pc, 32'h0);
      chk("deq_inst_empty", deq_inst, NOP);
    end
  endtask

  // driver: one cycle of stimulus, scoreboard updated at the edge
  task automatic step(input logic fl, input logic ev, input logic [31:0] pc, input logic dr);
    logic acc_e;
    logic acc_d;
    @(negedge clk);
    check_head();
    flush     = fl;
    enq_valid = ev;
    enq_pc    = pc;
    enq_inst  = inst_of(pc);
    deq_ready = dr;
    acc_e = ev && !fl && (exp_q.size() != DEPTH);
    acc_d = dr && !fl && (exp_q.size() != 0);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (acc_d) void'(exp_q.pop_front());
      if (acc_e) exp_q.push_back({pc, inst_of(pc)});
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_enq_ready"}, 32'(enq_ready), 32'd1);
    chk({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, "_deq_valid"}, 32'(deq_valid), 32'd0);
    chk({tag, "_deq_pc"}, deq_pc, 32'h0);
    chk({tag, "_deq_inst"}, deq_inst, NOP);
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_pc    = 32'h0;
    enq_inst  = 32'h0;
    deq_ready = 1'b0;

    // fill with decode stalled; the fifth offer is ignored
    add_vec(0, 1, 32'h0,  0, 1, 0, 1, 1);
    add_vec(0, 1, 32'h4,  0, 2, 0, 1, 1);
    add_vec(0, 1, 32'h8,  0, 3, 1, 1, 1);
    add_vec(0, 1, 32'hC,  0, 4, 1, 0, 1);
    add_vec(0, 1, 32'h10, 0, 4, 1, 0, 1);
    // drain, then a dequeue attempt while empty
    add_vec(0, 0, 32'h0, 1, 3, 1, 1, 1);
    add_vec(0, 0, 32'h0, 1, 2, 0, 1, 1);
    add_vec(0, 0, 32'h0, 1, 1, 0, 1, 1);
    add_vec(0, 0, 32'h0, 1, 0, 0, 1, 0);
    add_vec(0, 0, 32'h0, 1, 0, 0, 1, 0);
    // streaming: prime one entry, then enq+deq every cycle for 10 cycles
    add_vec(0, 1, 32'h100, 1, 1, 0, 1, 1);
    for (int i = 1; i <= 10; i++) add_vec(0, 1, 32'h100 + 32'(4 * i), 1, 1, 0, 1, 1);
    add_vec(0, 0, 32'h0, 1, 0, 0, 1, 0);
    // full plus dequeue: the offer at count 4 is refused
    for (int i = 0; i < 4; i++) add_vec(0, 1, 32'h200 + 32'(4 * i), 0, i + 1, (i >= 2), (i != 3), 1);
    add_vec(0, 1, 32'h210, 1, 3, 1, 1, 1);
    add_vec(0, 0, 32'h0, 1, 2, 0, 1, 1);
    add_vec(0, 0, 32'h0, 1, 1, 0, 1, 1);
    add_vec(0, 0, 32'h0, 1, 0, 0, 1, 0);
    // flush at count 3 with an enqueue and a dequeue offered
    add_vec(0, 1, 32'h300, 0, 1, 0, 1, 1);
    add_vec(0, 1, 32'h304, 0, 2, 0, 1, 1);
    add_vec(0, 1, 32'h308, 0, 3, 1, 1, 1);
    add_vec(1, 1, 32'h30C, 1, 0, 0, 1, 0);
    add_vec(0, 0, 32'h0,   0, 0, 0, 1, 0);
    add_vec(0, 1, 32'h400, 0, 1, 0, 1, 1);
    add_vec(0, 0, 32'h0,   1, 0, 0, 1, 0);

    // reset state
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven main run
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].fl, vecs[i].ev, vecs[i].pc, vecs[i].dr);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_almost_full", i), 32'(almost_full), 32'(vecs[i].af));
      chk($sformatf("v%0d_enq_ready", i), 32'(enq_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d_deq_valid", i), 32'(deq_valid), 32'(vecs[i].val));
    end

    // head stays put while decode stalls
    step(0, 1, 32'h600, 0);
    step(0, 1, 32'h604, 0);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    chk("hold_pc", deq_pc, 32'h600);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);

    // random traffic against the scoreboard
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           32'h1000 + 32'(4 * i), 1'($urandom_range(0, 1)));
    end
    while (exp_q.size() != 0) step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);

    // asynchronous reset between edges with two entries held
    step(0, 1, 32'h700, 0);
    step(0, 1, 32'h704, 0);
    chk("pre_reset_count", 32'(count), 32'd2);
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 32'h800, 0);
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);
    check_head();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
